// File: rtl/decryption_cfg_bank.sv
`default_nettype none
// ============================================================================
// Module   : decryption_cfg_bank
// Purpose  : Configuration register bank for the decryption top level.
//            Holds the MUX/DEMUX select value and NUM_KEYS cipher keys behind
//            a shadow/commit scheme so that every live output changes in the
//            same clock cycle. Adds a sticky write lock, a read-only status
//            register and a saturating error counter.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            addr   - register address
//            read   - read request, single-cycle pulse
//            write  - write request, single-cycle pulse
//            wdata  - write data
//            rdata  - read data, valid while done = 1
//            done   - access complete, single-cycle pulse
//            error  - access failed, qualified by done
//            select - live (committed) select value
//            keys   - live keys, key i at [i*reg_width +: reg_width]
// Register map:
//            0x00          SELECT (rw, shadow)
//            0x02          CTRL   (wo) bit0 = commit, bit1 = lock
//            0x04          STATUS (ro) [0] lock, [1] pending, [15:8] err_cnt
//            KEY_BASE+2*i  KEY i  (rw, shadow)
// Revision : 1.0 - initial release
// ============================================================================
module decryption_cfg_bank #(
  parameter int unsigned addr_width = 8,
  parameter int unsigned reg_width  = 16,
  parameter int unsigned NUM_KEYS   = 3,
  parameter int unsigned KEY_BASE   = 'h10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [addr_width-1:0]         addr,
  input  logic                          read,
  input  logic                          write,
  input  logic [reg_width-1:0]          wdata,
  output logic [reg_width-1:0]          rdata,
  output logic                          done,
  output logic                          error,
  output logic [reg_width-1:0]          select,
  output logic [NUM_KEYS*reg_width-1:0] keys
);

  // Fixed register addresses
  localparam logic [addr_width-1:0] c_addr_select = addr_width'(0);
  localparam logic [addr_width-1:0] c_addr_ctrl   = addr_width'(2);
  localparam logic [addr_width-1:0] c_addr_status = addr_width'(4);

  // CTRL bit positions
  localparam int unsigned c_ctrl_commit = 0;
  localparam int unsigned c_ctrl_lock   = 1;

  localparam logic [7:0] c_err_cnt_max = 8'hFF;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [reg_width-1:0]          r_sel_shadow;
  logic [reg_width-1:0]          r_sel_live;
  logic [NUM_KEYS*reg_width-1:0] r_key_shadow;
  logic [NUM_KEYS*reg_width-1:0] r_key_live;
  logic                          r_lock;
  logic                          r_pending;
  logic [7:0]                    r_err_cnt;
  logic [reg_width-1:0]          r_rdata;
  logic                          r_done;
  logic                          r_error;

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic                 w_is_select;
  logic                 w_is_ctrl;
  logic                 w_is_status;
  logic [NUM_KEYS-1:0]  w_key_hit;
  logic                 w_is_key;
  logic                 w_mapped;

  assign w_is_select = (addr == c_addr_select);
  assign w_is_ctrl   = (addr == c_addr_ctrl);
  assign w_is_status = (addr == c_addr_status);

  // Each key has its own exact-match comparator, so odd addresses between
  // keys and addresses past the last key fall out as unmapped naturally.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key_dec
    localparam logic [addr_width-1:0] c_key_addr = addr_width'(KEY_BASE + 2 * i);
    assign w_key_hit[i] = (addr == c_key_addr);
  end

  assign w_is_key = |w_key_hit;
  assign w_mapped = w_is_select | w_is_ctrl | w_is_status | w_is_key;

  // --------------------------------------------------------------------------
  // Access qualification
  // --------------------------------------------------------------------------
  logic w_req;
  logic w_collision;
  logic w_bad_dir;
  logic w_locked_wr;
  logic w_err;
  logic w_rd_ok;
  logic w_wr_ok;

  assign w_req       = read | write;
  assign w_collision = read & write;
  // STATUS is read-only and CTRL is write-only
  assign w_bad_dir   = (write & w_is_status) | (read & w_is_ctrl);
  // Once locked, every writable register rejects writes (CTRL included, so
  // the lock can never be undone and no further commit can happen).
  assign w_locked_wr = write & r_lock & (w_is_select | w_is_key | w_is_ctrl);

  assign w_err   = w_req & (w_collision | ~w_mapped | w_bad_dir | w_locked_wr);
  assign w_rd_ok = read  & ~write & ~w_err;
  assign w_wr_ok = write & ~read  & ~w_err;

  // --------------------------------------------------------------------------
  // Read data mux
  // --------------------------------------------------------------------------
  logic [reg_width-1:0] w_status;
  logic [reg_width-1:0] w_key_rdata;
  logic [reg_width-1:0] w_rd_data;

  always_comb begin
    w_status                = '0;
    w_status[0]             = r_lock;
    w_status[1]             = r_pending;
    w_status[15:8]          = r_err_cnt;
  end

  // Key hits are one-hot, so a priority-free scan is sufficient.
  always_comb begin
    w_key_rdata = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (w_key_hit[i]) begin
        w_key_rdata = r_key_shadow[i*reg_width +: reg_width];
      end
    end
  end

  // Reads of SELECT/KEY return the shadow copy, i.e. what the next commit
  // will publish, not what is currently driving the datapath.
  always_comb begin
    w_rd_data = '0;
    if (w_is_select) begin
      w_rd_data = r_sel_shadow;
    end else if (w_is_status) begin
      w_rd_data = w_status;
    end else if (w_is_key) begin
      w_rd_data = w_key_rdata;
    end
  end

  // --------------------------------------------------------------------------
  // Sequential logic
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_shadow <= '0;
      r_sel_live   <= '0;
      r_key_shadow <= '0;
      r_key_live   <= '0;
      r_lock       <= 1'b0;
      r_pending    <= 1'b0;
      r_err_cnt    <= '0;
      r_rdata      <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      // Every request, good or bad, gets exactly one done pulse next cycle.
      r_done  <= w_req;
      r_error <= w_err;

      // rdata only moves on a request; idle cycles keep the last value.
      // Failed accesses and writes return zero.
      if (w_req) begin
        r_rdata <= w_rd_ok ? w_rd_data : '0;
      end

      if (w_err && (r_err_cnt != c_err_cnt_max)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end

      if (w_wr_ok) begin
        if (w_is_select) begin
          r_sel_shadow <= wdata;
          r_pending    <= 1'b1;
        end

        for (int i = 0; i < NUM_KEYS; i++) begin
          if (w_key_hit[i]) begin
            r_key_shadow[i*reg_width +: reg_width] <= wdata;
          end
        end
        if (w_is_key) begin
          r_pending <= 1'b1;
        end

        // Commit and lock may arrive together: the commit uses the current
        // shadows in this same edge and the lock only guards later writes.
        if (w_is_ctrl) begin
          if (wdata[c_ctrl_commit]) begin
            r_sel_live <= r_sel_shadow;
            r_key_live <= r_key_shadow;
            r_pending  <= 1'b0;
          end
          if (wdata[c_ctrl_lock]) begin
            r_lock <= 1'b1;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rdata  = r_rdata;
  assign done   = r_done;
  assign error  = r_error;
  assign select = r_sel_live;
  assign keys   = r_key_live;

endmodule
`default_nettype wire

// File: tb/tb_decryption_cfg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_decryption_cfg_bank
// Purpose  : Self-checking bench for decryption_cfg_bank. A table of directed
//            vectors, hand-written reset/saturation/back-to-back sequences and
//            a random run, all compared against a register-map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decryption_cfg_bank;

  localparam int unsigned AW = 8;
  localparam int unsigned RW = 16;
  localparam int unsigned NK = 3;
  localparam int unsigned KB = 'h10;

  logic              clk;
  logic              rst_n;
  logic [AW-1:0]     addr;
  logic              read;
  logic              write;
  logic [RW-1:0]     wdata;
  logic [RW-1:0]     rdata;
  logic              done;
  logic              error;
  logic [RW-1:0]     select;
  logic [NK*RW-1:0]  keys;

  decryption_cfg_bank #(
    .addr_width (AW),
    .reg_width  (RW),
    .NUM_KEYS   (NK),
    .KEY_BASE   (KB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr   (addr),
    .read   (read),
    .write  (write),
    .wdata  (wdata),
    .rdata  (rdata),
    .done   (done),
    .error  (error),
    .select (select),
    .keys   (keys)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: register map as plain variables
  // --------------------------------------------------------------------------
  logic [15:0] m_sel_sh, m_sel_live;
  logic [15:0] m_key_sh   [NK];
  logic [15:0] m_key_live [NK];
  bit          m_lock, m_pend;
  int          m_errcnt;
  bit          m_rd_known;
  logic [15:0] m_last_rd;

  task automatic model_reset();
    m_sel_sh = 0; m_sel_live = 0;
    for (int i = 0; i < NK; i++) begin m_key_sh[i] = 0; m_key_live[i] = 0; end
    m_lock = 0; m_pend = 0; m_errcnt = 0;
    m_rd_known = 1; m_last_rd = 0;
  endtask

  function automatic logic [63:0] model_keys();
    logic [63:0] k = 0;
    for (int i = 0; i < NK; i++) k[i*16 +: 16] = m_key_live[i];
    return k;
  endfunction

  // kind: 0 select, 1 ctrl, 2 status, 3 key, -1 unmapped
  task automatic model_access(input bit rd, input bit wr, input int a, input logic [15:0] d,
                              output bit e_err, output logic [15:0] e_rd, output bit rd_valid);
    int kind, kidx;
    kidx = 0;
    if (a == 0) kind = 0;
    else if (a == 2) kind = 1;
    else if (a == 4) kind = 2;
    else if (a >= KB && ((a - KB) % 2 == 0) && ((a - KB) / 2 < NK)) begin
      kind = 3; kidx = (a - KB) / 2;
    end else kind = -1;

    e_err = (rd && wr) || (kind < 0) || (wr && kind == 2) || (rd && kind == 1) ||
            (wr && m_lock);
    e_rd = 0;
    rd_valid = 0;
    if (e_err) begin
      if (m_errcnt < 255) m_errcnt++;
      rd_valid = 1;
    end else if (rd) begin
      rd_valid = 1;
      case (kind)
        0: e_rd = m_sel_sh;
        2: e_rd = {m_errcnt[7:0], 6'b0, m_pend, m_lock};
        default: e_rd = m_key_sh[kidx];
      endcase
    end else begin
      case (kind)
        0: begin m_sel_sh = d; m_pend = 1; end
        3: begin m_key_sh[kidx] = d; m_pend = 1; end
        default: begin
          if (d[0]) begin
            m_sel_live = m_sel_sh;
            for (int i = 0; i < NK; i++) m_key_live[i] = m_key_sh[i];
            m_pend = 0;
          end
          if (d[1]) m_lock = 1;
        end
      endcase
    end
    m_rd_known = rd_valid;
    m_last_rd  = e_rd;
  endtask

  task automatic check_live(input string tag);
    chk({tag, "_select"}, 64'(select), 64'(m_sel_live));
    chk({tag, "_keys"},   64'(keys),   model_keys());
  endtask

  // One request, one cycle; outputs checked #1 after the edge that follows.
  task automatic access(input bit rd, input bit wr, input logic [7:0] a, input logic [15:0] d);
    bit e_err, rd_valid;
    logic [15:0] e_rd;
    read = rd; write = wr; addr = a; wdata = d;
    model_access(rd, wr, int'(a), d, e_err, e_rd, rd_valid);
    @(posedge clk); #1;
    read = 0; write = 0;
    chk("done", 64'(done), 64'(1));
    chk("error", 64'(error), 64'(e_err));
    if (rd_valid) chk("rdata", 64'(rdata), 64'(e_rd));
    check_live("acc");
  endtask

  task automatic idle();
    read = 0; write = 0;
    @(posedge clk); #1;
    chk("idle_done", 64'(done), 64'(0));
    chk("idle_error", 64'(error), 64'(0));
    if (m_rd_known) chk("idle_rdata_hold", 64'(rdata), 64'(m_last_rd));
    check_live("idle");
  endtask

  task automatic do_reset();
    rst_n = 0;
    read = 0; write = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    bit          rd;
    bit          wr;
    logic [7:0]  a;
    logic [15:0] d;
    bit          exp_err;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[14];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : main
    rst_n = 0; read = 0; write = 0; addr = 0; wdata = 0;

    vecs[0]  = '{0, 1, 8'h10, 16'h0003, 0, 16'h0000}; // key0 shadow
    vecs[1]  = '{1, 0, 8'h10, 16'h0000, 0, 16'h0003}; // shadow readback
    vecs[2]  = '{1, 0, 8'h04, 16'h0000, 0, 16'h0002}; // pending
    vecs[3]  = '{0, 1, 8'h02, 16'h0001, 0, 16'h0000}; // commit
    vecs[4]  = '{1, 0, 8'h04, 16'h0000, 0, 16'h0000}; // pending cleared
    vecs[5]  = '{0, 1, 8'h00, 16'h0002, 0, 16'h0000}; // select shadow
    vecs[6]  = '{0, 1, 8'h12, 16'h0005, 0, 16'h0000}; // key1 shadow
    vecs[7]  = '{0, 1, 8'h02, 16'h0001, 0, 16'h0000}; // commit both
    vecs[8]  = '{1, 0, 8'h00, 16'h0000, 0, 16'h0002};
    vecs[9]  = '{0, 1, 8'h02, 16'h0002, 0, 16'h0000}; // lock
    vecs[10] = '{0, 1, 8'h00, 16'h0001, 1, 16'h0000}; // locked write
    vecs[11] = '{1, 0, 8'h04, 16'h0000, 0, 16'h0101}; // lock=1 err_cnt=1
    vecs[12] = '{1, 0, 8'h02, 16'h0000, 1, 16'h0000}; // read of CTRL
    vecs[13] = '{1, 0, 8'h14, 16'h0000, 0, 16'h0000}; // key2 still readable

    // ---- reset, then reset asserted in the middle of a write --------------
    do_reset();
    idle();
    @(posedge clk); #1;
    write = 1; addr = 8'h00; wdata = 16'h1234;
    #3 rst_n = 0;
    #1;
    chk("rst_select", 64'(select), 64'(0));
    chk("rst_keys",   64'(keys),   64'(0));
    chk("rst_done",   64'(done),   64'(0));
    chk("rst_error",  64'(error),  64'(0));
    chk("rst_rdata",  64'(rdata),  64'(0));
    write = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    access(1, 0, 8'h04, 16'h0);
    chk("rst_status", 64'(rdata), 64'(16'h0000));
    access(1, 0, 8'h00, 16'h0);
    chk("rst_sel_shadow_dropped", 64'(rdata), 64'(16'h0000));

    // ---- table --------------------------------------------------------------
    for (int i = 0; i < 14; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d);
      chk($sformatf("tbl%0d_error", i), 64'(error), 64'(vecs[i].exp_err));
      if (vecs[i].rd || vecs[i].exp_err)
        chk($sformatf("tbl%0d_rdata", i), 64'(rdata), 64'(vecs[i].exp_rd));
      if (i == 3) chk("tbl_key0_live", 64'(keys[15:0]), 64'(16'h0003));
      if (i == 7) begin
        chk("tbl_sel_live",  64'(select),      64'(16'h0002));
        chk("tbl_key1_live", 64'(keys[31:16]), 64'(16'h0005));
      end
      if (i == 10) chk("tbl_sel_locked", 64'(select), 64'(16'h0002));
    end
    idle();

    // ---- error counter saturation ------------------------------------------
    for (int i = 0; i < 260; i++) begin
      case (i % 4)
        0: access(1, 0, 8'h11, 16'h0);
        1: access(0, 1, 8'h20, 16'hFFFF);
        2: access(1, 1, 8'h00, 16'h0007);
        default: access(0, 1, 8'h04, 16'h00FF);
      endcase
    end
    access(1, 0, 8'h04, 16'h0);
    chk("sat_status", 64'(rdata), 64'(16'hFF01));

    // ---- back-to-back write then read --------------------------------------
    do_reset();
    access(0, 1, 8'h14, 16'hA5A5);
    access(1, 0, 8'h14, 16'h0);
    chk("b2b_rdata", 64'(rdata), 64'(16'hA5A5));
    access(0, 1, 8'h02, 16'h0003);
    chk("b2b_key2_live", 64'(keys[47:32]), 64'(16'hA5A5));
    chk("b2b_lock", 64'(dut.error), 64'(0));
    access(1, 0, 8'h04, 16'h0);
    chk("b2b_status", 64'(rdata), 64'(16'h0001));

    // ---- random run ---------------------------------------------------------
    do_reset();
    for (int i = 0; i < 600; i++) begin
      int sel;
      logic [7:0]  a;
      logic [15:0] d;
      sel = int'($urandom_range(0, 11));
      case (sel)
        0: a = 8'h00;  1: a = 8'h02;  2: a = 8'h04;  3: a = 8'h10;
        4: a = 8'h12;  5: a = 8'h14;  6: a = 8'h11;  7: a = 8'h16;
        8: a = 8'h00;  9: a = 8'h02;  10: a = 8'h10;
        default: a = 8'($urandom);
      endcase
      d = 16'($urandom);
      if (a == 8'h02 && $urandom_range(0, 63) != 0) d[1] = 1'b0;
      sel = int'($urandom_range(0, 19));
      if (sel < 9) access(1, 0, a, d);
      else if (sel < 18) access(0, 1, a, d);
      else if (sel == 18) access(1, 1, a, d);
      else idle();
    end
    access(1, 0, 8'h04, 16'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
